// File: rtl/cheshire_pkg.sv
// Shared interrupt-layout definitions for the Cheshire interrupt path.
//
// Contents:
//   NumExtIntrs     - number of external interrupt lines into the SoC.
//   NumIntIntrs     - number of internal interrupt bits, including bit 0
//                     (bit 0 is tied to 0).
//   cheshire_intr_t - packed interrupt vector seen by the PLIC. The external
//                     field is in the MSBs and the internal field is in the
//                     LSBs. cheshire_intr_cond.intr_o has this layout when
//                     its widths match these constants.
package cheshire_pkg;

    localparam int unsigned NumExtIntrs = 8;
    localparam int unsigned NumIntIntrs = 20;

    typedef struct packed {
        logic [NumExtIntrs-1:0] ext;
        logic [NumIntIntrs-1:0] intn;
    } cheshire_intr_t;

endpackage

// File: rtl/cheshire_intr_filter.sv
// Conditions one raw external interrupt line. It synchronises the line,
// applies polarity and rejects glitches.
//
// Ports:
//   clk_i  - system clock
//   rst_i  - synchronous, active-high reset
//   raw_i  - raw asynchronous interrupt line
//   filt_o - filtered, active-high level (registered)
//
// The synchroniser flops reset to the inactive raw level (Polarity). After
// reset the polarity-corrected value is therefore 0, and the line does not
// start with a false transition.
module cheshire_intr_filter #(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned FilterCycles = 4,
    parameter logic        Polarity     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic filt_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  act;
    logic                  filt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SyncStages{Polarity}};
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], raw_i};
        end
    end

    assign act = sync_q[SyncStages-1] ^ Polarity;

    generate
        if (FilterCycles == 0) begin : g_bypass
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    filt_q <= 1'b0;
                end else begin
                    filt_q <= act;
                end
            end
        end else begin : g_filter
            localparam int unsigned CntW = $clog2(FilterCycles + 1);
            localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

            logic [CntW-1:0] cnt_q;

            // A new level is accepted only after it has differed from filt
            // for FilterCycles consecutive cycles. Any cycle where the two
            // agree restarts the count.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else if (act == filt_q) begin
                    cnt_q  <= '0;
                end else if (cnt_q == CntLast) begin
                    cnt_q  <= '0;
                    filt_q <= act;
                end else begin
                    cnt_q  <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    assign filt_o = filt_q;

endmodule

// File: rtl/cheshire_intr_cond.sv
// Interrupt conditioning stage that sits directly in front of the PLIC.
//
// Each external source is synchronised, glitch-filtered and
// polarity-corrected. A source then either follows its filtered level
// (level mode) or latches rising edges into a sticky pending bit that an
// acknowledge clears (edge mode). Internal sources are registered once so
// they line up with the registered external field.
//
// Ports:
//   clk_i      - system clock
//   rst_i      - synchronous, active-high reset
//   intr_int_i - internal sources, synchronous to clk_i; bit 0 is ignored
//   intr_ext_i - raw asynchronous external sources
//   ack_i      - one-cycle acknowledge per source (edge-mode sources only)
//   intr_o     - {pending, internal} packed vector; bit 0 is always 0
//   pending_o  - conditioned state per external source
//   overflow_o - sticky flag: an edge arrived while already pending
module cheshire_intr_cond
    import cheshire_pkg::*;
#(
    parameter int unsigned       NumSrc       = NumExtIntrs,
    parameter int unsigned       NumInt       = NumIntIntrs,
    parameter int unsigned       SyncStages   = 2,
    parameter int unsigned       FilterCycles = 4,
    parameter logic [NumSrc-1:0] EdgeMask     = '0,
    parameter logic [NumSrc-1:0] PolarityMask = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumInt-1:0]        intr_int_i,
    input  logic [NumSrc-1:0]        intr_ext_i,
    input  logic [NumSrc-1:0]        ack_i,
    output logic [NumSrc+NumInt-1:0] intr_o,
    output logic [NumSrc-1:0]        pending_o,
    output logic [NumSrc-1:0]        overflow_o
);

    logic [NumSrc-1:0] filt;
    logic [NumSrc-1:0] filt_prev_q;
    logic [NumSrc-1:0] rise;
    logic [NumSrc-1:0] pend_q, pend_d;
    logic [NumSrc-1:0] ovf_q, ovf_d;
    logic [NumInt-1:0] intr_int_q;

    genvar gi;
    generate
        for (gi = 0; gi < NumSrc; gi++) begin : g_src
            cheshire_intr_filter #(
                .SyncStages   (SyncStages),
                .FilterCycles (FilterCycles),
                .Polarity     (PolarityMask[gi])
            ) u_filter (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .raw_i  (intr_ext_i[gi]),
                .filt_o (filt[gi])
            );
        end
    endgenerate

    // filt_prev_q holds the value filt had on the previous cycle, so a rise
    // is seen in the cycle right after the filter accepts the new level.
    // This is the same cycle in which level-mode sources take pend <= filt,
    // so both modes have the same latency.
    assign rise = filt & ~filt_prev_q;

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < NumSrc; i++) begin
            if (!EdgeMask[i]) begin
                pend_d[i] = filt[i];
                ovf_d[i]  = 1'b0;
            end else if (rise[i]) begin
                // A new edge always leaves the source pending. If it coincides
                // with an ack, the ack consumed the old event and the new edge
                // is not counted as an overflow.
                pend_d[i] = 1'b1;
                if (ack_i[i]) begin
                    ovf_d[i] = 1'b0;
                end else if (pend_q[i]) begin
                    ovf_d[i] = 1'b1;
                end
            end else if (ack_i[i]) begin
                pend_d[i] = 1'b0;
                ovf_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_prev_q <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            intr_int_q  <= '0;
        end else begin
            filt_prev_q <= filt;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            // Bit 0 is the reserved "no interrupt" ID and is forced to 0.
            intr_int_q  <= {intr_int_i[NumInt-1:1], 1'b0};
        end
    end

    assign intr_o     = {pend_q, intr_int_q};
    assign pending_o  = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: doc/cheshire_intr_cond.md
Name: cheshire_intr_cond

Overview:
- Interrupt conditioning stage directly upstream of the PLIC.
- Takes raw, asynchronous external interrupt lines and the already-synchronous internal interrupt sources, and produces the packed interrupt vector consumed by the PLIC. Its layout is cheshire_intr_t when NumSrc == NumExtIntrs.
- Per external source it synchronises, glitch-filters, applies polarity, and optionally converts edges to sticky pending bits cleared by an acknowledge.

Parameters:
- NumSrc, 8: number of raw external interrupt sources (≥1).
- NumInt, 20: internal interrupt bits including the zero bit; equals NumIntIntrs.
- SyncStages, 2: synchroniser flops per external source (≥2).
- FilterCycles, 4: consecutive stable cycles required to accept a level change; 0 bypasses the filter.
- EdgeMask, '0 [NumSrc]: per-source mode; 1 = rising-edge latched, 0 = level.
- PolarityMask, '0 [NumSrc]: per-source polarity; 1 = active-low raw input.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- intr_int_i  in  NumInt  internal sources, synchronous to clk_i; bit 0 is ignored.
- intr_ext_i  in  NumSrc  raw asynchronous external sources.
- ack_i  in  NumSrc  one-cycle pulse; clears pending/overflow of edge-mode sources.
- intr_o  out  NumSrc+NumInt  packed vector to the PLIC; the external field sits in the MSBs, internal bits in the LSBs.
- pending_o  out  NumSrc  current conditioned state per external source.
- overflow_o  out  NumSrc  sticky: an edge arrived while the source was already pending.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All synchroniser flops load PolarityMask[i], i.e. the inactive raw level.
  - Filtered state, filter counters, pending, overflow and all intr_o bits reset to 0.
- Synchroniser: SyncStages-flop chain per source. After the chain, apply polarity: act = sync_out XOR PolarityMask[i].
- Filter:
  - Counter width is $clog2(FilterCycles+1).
  - Each cycle that act != filt, cnt increments. When cnt == FilterCycles-1 and the mismatch persists, filt <= act and cnt <= 0.
  - Any cycle with act == filt resets cnt to 0, so glitches shorter than FilterCycles cycles are discarded.
  - With FilterCycles == 0, filt <= act every cycle.
- Level mode (EdgeMask[i]=0):
  - pend <= filt.
  - ack_i is ignored; overflow stays 0.
- Edge mode (EdgeMask[i]=1): rise = filt rising (new filt 1, old filt 0).
  - rise & !pend: pend <= 1.
  - rise & pend & !ack: overflow <= 1; pend stays 1.
  - ack & !rise: pend <= 0, overflow <= 0.
  - ack & rise in the same cycle: pend stays 1, overflow <= 0 (edge wins, not counted as overflow).
  - ack while not pending: no effect.
- Output:
  - intr_o[NumInt +: NumSrc] = pend (registered).
  - intr_o[NumInt-1:1] = intr_int_i[NumInt-1:1], registered once for alignment.
  - intr_o[0] is constant 0.
- Latency, raw edge to intr_o:
  - External: SyncStages + FilterCycles + 1 clock edges, counted from the first sampling edge.
  - Internal: 1 cycle.
- Reset mid-operation drops all pending state; after release, external inputs are re-evaluated from the inactive level. A source held active across reset therefore re-triggers an edge after the full latency.

Decomposition:
- cheshire_pkg owns NumIntIntrs, NumExtIntrs and cheshire_intr_t; intr_o maps onto cheshire_intr_t when widths match.
- One sub-module, cheshire_intr_filter: a single-source synchroniser, polarity and glitch filter with output filt. It is instantiated NumSrc times.
- Edge/pending logic and output packing stay in the top level.

Test Plan:
- Reset, then idle with inputs inactive: intr_o == 0, pending_o == 0, overflow_o == 0; active-low sources idle high show no activity.
- Level source 0, SyncStages=2, FilterCycles=4, raw held high 10 cycles: intr_o[NumInt] rises exactly 7 edges after first sample and falls 7 edges after release.
- Glitch filtering, level source: a 3-cycle high pulse gives no output; a 4-cycle pulse gives a 4-cycle high output.
- Edge source 1, EdgeMask[1]=1, two rising edges with no ack: pending_o[1]=1 after the first, overflow_o[1]=1 after the second. ack_i[1] pulse clears both next cycle.
- Simultaneous ack_i and a new filtered rise on an edge source: pending_o stays 1 and overflow_o stays 0.
- Internal: intr_int_i = 20'hFFFFF gives intr_o[19:1] all 1 and intr_o[0]=0 one cycle later. Asserting rst_i mid-pending clears all outputs on the next edge.
